instruction_fetch_unit: RTL and testbench

Fetch stage that sits directly upstream of the processor's decode logic. It generates sequential 64-bit PCs and issues one-at-a-time requests to a variable-latency instruction memory. Returned 32-bit instructions are buffered, tagged with their PC, in a DEPTH-entry FIFO and presented to decode over a valid/ready handshake. A redirect, driven by a taken branch from the branch adder/mux path, flushes the buffer and discards any in-flight response.

---
 rtl/instruction_fetch_unit_if.sv | 43 ++++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's memory-side, decode-side and redirect signals.
// Handshake rule for every valid/ready pair in this bundle: a transfer happens
// in a cycle where both valid and ready are 1 at the rising clock edge; valid
// never waits on ready, and the consumer may drive ready at any time.
interface instruction_fetch_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // instruction memory request / response
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [63:0]   imem_addr;
  logic          imem_resp_valid;
  logic [31:0]   imem_resp_data;
  // decode side
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [63:0]   inst_pc;
  // redirect from the branch path
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  // status / debug
  logic [CW-1:0] fifo_count;
  logic [1:0]    fetch_state;

  // fetch unit side
  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
           fifo_count, fetch_state,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  // memory / decode / branch side
  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
           fifo_count, fetch_state,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch with one request in flight, a DEPTH-entry
// PC-tagged instruction buffer toward decode, and redirect/flush handling.
// fetch_state exposes the request tracker: 0 idle, 1 waiting (keep response),
// 2 dropping (discard response).
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input logic clk,
  input logic reset,
  instruction_fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [63:0]   pc_mem_q   [DEPTH];

  logic [CW:0]   credit;
  logic          req_valid;
  logic          accept;
  logic          inst_valid;
  logic          pop;
  logic          push;

  // Handshake decisions. The credit counts the in-flight kept response as
  // occupied, and deliberately ignores a same-cycle pop.
  always_comb begin
    credit     = {1'b0, count_q} + {{CW{1'b0}}, (state_q == ST_WAIT)};
    req_valid  = reset && !bus.redirect_valid
                 && ((state_q == ST_IDLE) || bus.imem_resp_valid)
                 && (credit < (CW+1)'(DEPTH));
    accept     = req_valid && bus.imem_req_ready;
    inst_valid = reset && (count_q != '0) && !bus.redirect_valid;
    pop        = inst_valid && bus.inst_ready;
    push       = reset && !bus.redirect_valid && bus.imem_resp_valid
                 && (state_q == ST_WAIT);
  end

  // Next-state for the request tracker, fetch PC and buffer bookkeeping;
  // a redirect overrides push, pop and request.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {bus.redirect_pc[63:2], 2'b00};
      // An outstanding response becomes unwanted; if it is arriving right
      // now it is simply swallowed.
      if (state_q != ST_IDLE) begin
        state_d = bus.imem_resp_valid ? ST_IDLE : ST_DROP;
      end
    end else begin
      if (accept) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 64'd4;
        state_d    = ST_WAIT;
      end else if (bus.imem_resp_valid && (state_q != ST_IDLE)) begin
        state_d = ST_IDLE;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= bus.imem_resp_data;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst           = inst_mem_q[rd_ptr_q];
  assign bus.inst_pc        = pc_mem_q[rd_ptr_q];
  assign bus.fifo_count     = count_q;
  assign bus.fetch_state    = state_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a variable-latency memory model, random
// decode back-pressure, redirects and resets, checked each cycle against a
// queue-based reference of what decode should see.
module tb_instruction_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'd0;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.DEPTH(DEPTH)) bus ();

  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  bit          rst_drv;
  int          rst_pm;
  int          rdy_pct, ir_pct, lat_lo, lat_hi, redir_pct;
  bit          redir_drv;
  bit          redir_on_resp;
  logic [63:0] redir_pc_drv;

  // memory model
  bit          mem_busy;
  logic [63:0] mem_addr;
  int          mem_remain;

  // reference model: PCs decode should see, in order
  logic [63:0] exp_q[$];
  logic [63:0] m_pc;
  logic [63:0] m_out_pc;
  bit          m_out;
  bit          m_keep;

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ pc[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // compare this cycle's outputs with the model, then advance the model
  task automatic model_cycle();
    bit exp_req, exp_iv, acc;
    int credit;
    credit  = exp_q.size() + ((m_out && m_keep) ? 1 : 0);
    exp_req = reset && !bus.redirect_valid && (!m_out || bus.imem_resp_valid) && (credit < DEPTH);
    exp_iv  = reset && (exp_q.size() != 0) && !bus.redirect_valid;
    check("req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
    if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
    check("inst_valid", 64'(bus.inst_valid), 64'(exp_iv));
    if (exp_iv) begin
      check("inst_pc", bus.inst_pc, exp_q[0]);
      check("inst", 64'(bus.inst), 64'(inst_of(exp_q[0])));
    end
    check("fifo_count", 64'(bus.fifo_count), 64'(exp_q.size()));
    acc = exp_req && bus.imem_req_ready;
    if (!reset) begin
      exp_q.delete();
      m_pc   = RESET_PC;
      m_out  = 1'b0;
      m_keep = 1'b0;
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      m_pc = {bus.redirect_pc[63:2], 2'b00};
      if (m_out) begin
        if (bus.imem_resp_valid) m_out = 1'b0;
        else                     m_keep = 1'b0;
      end
    end else begin
      if (exp_iv && bus.inst_ready) void'(exp_q.pop_front());
      if (m_out && bus.imem_resp_valid) begin
        if (m_keep) exp_q.push_back(m_out_pc);
        m_out = 1'b0;
      end
      if (acc) begin
        m_out    = 1'b1;
        m_keep   = 1'b1;
        m_out_pc = m_pc;
        m_pc     = m_pc + 64'd4;
      end
    end
  endtask

  // driver: one clock cycle of stimulus, checking, and memory bookkeeping
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_busy && mem_remain > 0) mem_remain--;
    reset                = rst_drv && ($urandom_range(0, 999) >= rst_pm);
    bus.imem_resp_valid  = mem_busy && (mem_remain == 0);
    bus.imem_resp_data   = bus.imem_resp_valid ? inst_of(mem_addr) : $urandom;
    bus.imem_req_ready   = (!mem_busy || bus.imem_resp_valid) && ($urandom_range(0, 99) < rdy_pct);
    bus.inst_ready       = $urandom_range(0, 99) < ir_pct;
    bus.redirect_pc      = {$urandom, $urandom};
    bus.redirect_valid   = 1'b0;
    if (redir_drv) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = redir_pc_drv;
    end else if (redir_on_resp && reset && bus.imem_resp_valid && m_out && m_keep) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = redir_pc_drv;
      redir_on_resp      = 1'b0;
    end else if ($urandom_range(0, 99) < redir_pct) begin
      bus.redirect_valid = 1'b1;
    end
    @(negedge clk);
    model_cycle();
    if (bus.imem_resp_valid) mem_busy = 1'b0;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      mem_busy   = 1'b1;
      mem_addr   = bus.imem_addr;
      mem_remain = $urandom_range(lat_lo, lat_hi);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // advance until a kept request is in flight, bounded
  task automatic wait_outstanding(input int max_cycles);
    int n;
    n = 0;
    while (!(m_out && m_keep) && n < max_cycles) begin
      step();
      n++;
    end
    check("wait_outstanding_timeout", 64'(m_out && m_keep), 64'd1);
  endtask

  initial begin
    rst_drv = 1'b0; rst_pm = 0;
    rdy_pct = 100; ir_pct = 100; lat_lo = 1; lat_hi = 1; redir_pct = 0;
    redir_drv = 1'b0; redir_on_resp = 1'b0; redir_pc_drv = '0;
    mem_busy = 1'b0; mem_addr = '0; mem_remain = 0;
    m_pc = RESET_PC; m_out_pc = '0; m_out = 1'b0; m_keep = 1'b0;
    reset = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;

    // reset, then streaming at one instruction per cycle
    steps(3);
    check("reset_count", 64'(bus.fifo_count), 64'd0);
    rst_drv = 1'b1;
    step();
    check("first_addr", bus.imem_addr, RESET_PC);
    for (int i = 0; i < 40; i++) begin
      step();
      check("stream_count_le1", 64'(bus.fifo_count <= 1), 64'd1);
    end

    // decode stalled: buffer fills, requests stop, then in-order drain
    ir_pct = 0;
    steps(20);
    check("full_count", 64'(bus.fifo_count), 64'(DEPTH));
    check("full_no_req", 64'(bus.imem_req_valid), 64'd0);
    ir_pct = 100;
    steps(20);

    // redirect while a long-latency request is outstanding
    lat_lo = 5; lat_hi = 5;
    wait_outstanding(20);
    steps(2);
    redir_drv = 1'b1; redir_pc_drv = 64'h100;
    step();
    redir_drv = 1'b0;
    steps(20);

    // redirect landing on the same cycle as a kept response; misaligned target
    lat_lo = 1; lat_hi = 1;
    redir_on_resp = 1'b1; redir_pc_drv = 64'h203;
    for (int i = 0; i < 20 && redir_on_resp; i++) step();
    check("redir_on_resp_timeout", 64'(redir_on_resp), 64'd0);
    steps(10);

    // fetch PC wraps through zero
    redir_drv = 1'b1; redir_pc_drv = 64'hFFFF_FFFF_FFFF_FFF9;
    step();
    redir_drv = 1'b0;
    steps(10);

    // reset with a request outstanding; stale response arrives after release
    lat_lo = 6; lat_hi = 6;
    wait_outstanding(20);
    step();
    rst_drv = 1'b0;
    steps(2);
    rst_drv = 1'b1;
    step();
    check("post_reset_count", 64'(bus.fifo_count), 64'd0);
    lat_lo = 1; lat_hi = 1;
    steps(15);

    // randomized mix
    for (int blk = 0; blk < 30; blk++) begin
      rdy_pct   = $urandom_range(30, 100);
      ir_pct    = $urandom_range(0, 100);
      lat_lo    = $urandom_range(1, 3);
      lat_hi    = lat_lo + $urandom_range(0, 4);
      redir_pct = $urandom_range(0, 6);
      rst_pm    = $urandom_range(0, 5);
      steps(100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
